// File: rtl/l2_bus_initiator.sv
// l2_bus_initiator: arbitrates NUM_CORES L1 requesters onto the shared L2
// request interface. Stores are written through to L2 and dmem; loads read
// dmem first, then look up / fill L2 and return data to the winning core.
// Optional macro BUS_RR_ARB_EN selects round-robin arbitration; when it is
// undefined, fixed priority is used (core 0 highest).
module l2_bus_initiator #(
  parameter int NUM_CORES = 2,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    req_valid,
  input  logic [NUM_CORES-1:0]    req_we,
  input  logic [NUM_CORES*32-1:0] req_addr,
  input  logic [NUM_CORES*32-1:0] req_wdata,
  output logic [NUM_CORES-1:0]    req_ack,
  output logic [31:0]             resp_rdata,
  output logic [6:0]              opcode_out,
  output logic [31:0]             bus_address_out,
  output logic [31:0]             bus_data_out,
  output logic [31:0]             l2_fill_data,
  input  logic [1:0]              cache_hit_in,
  input  logic [31:0]             data_from_L2,
  output logic                    dmem_rd_en,
  output logic                    dmem_wr_en,
  output logic [31:0]             dmem_addr,
  output logic [31:0]             dmem_wdata,
  input  logic [31:0]             dmem_rdata,
  input  logic                    dmem_rvalid,
  output logic [CNT_W-1:0]        l2_hit_count,
  output logic [CNT_W-1:0]        l2_miss_count
);

  localparam int IDX_W = (NUM_CORES > 2) ? 2 : 1;
  localparam logic [6:0] OP_IDLE  = 7'b0000000;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STORE,
    S_MEM_RD,
    S_LOOKUP,
    S_ACK
  } state_t;

  state_t state_reg, state_next;

  logic [IDX_W-1:0] winner_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [31:0]      fill_reg;
  logic [31:0]      rdata_reg;
  logic [CNT_W-1:0] hit_cnt_reg;
  logic [CNT_W-1:0] miss_cnt_reg;
  logic [1:0]       hit_cap_reg;
  logic [31:0]      l2_data_cap_reg;

  logic [31:0] core_addr  [NUM_CORES];
  logic [31:0] core_wdata [NUM_CORES];

  // Split the flattened request buses into per-core words
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
      assign core_addr[gi]  = req_addr[32*gi +: 32];
      assign core_wdata[gi] = req_wdata[32*gi +: 32];
    end
  endgenerate

  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;

`ifdef BUS_RR_ARB_EN
  logic [IDX_W-1:0] ptr_reg;

  // Round-robin search starting at the pointer; lowest offset wins
  always_comb begin
    int cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int off = NUM_CORES - 1; off >= 0; off--) begin
      cand = int'(ptr_reg) + off;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (req_valid[IDX_W'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  // Pointer advances past each winner
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (state_reg == S_IDLE && grant_any) begin
      if (grant_idx == IDX_W'(NUM_CORES - 1)) ptr_reg <= '0;
      else                                    ptr_reg <= grant_idx + IDX_W'(1);
    end
  end
`else
  // Fixed priority: lowest requesting index wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = NUM_CORES - 1; off >= 0; off--) begin
      if (req_valid[IDX_W'(off)]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(off);
      end
    end
  end
`endif

  // State register plus transaction context and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      winner_reg   <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      fill_reg     <= '0;
      rdata_reg    <= '0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (grant_any) begin
            winner_reg <= grant_idx;
            addr_reg   <= core_addr[grant_idx];
            wdata_reg  <= core_wdata[grant_idx];
            rdata_reg  <= '0;
          end
        end
        S_MEM_RD: begin
          if (dmem_rvalid) fill_reg <= dmem_rdata;
        end
        S_LOOKUP: begin
          // Only the 10 code counts as a hit; 01, 00 and 11 take the fill data
          if (hit_cap_reg == 2'b10) begin
            rdata_reg <= l2_data_cap_reg;
            if (hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
          end else begin
            rdata_reg <= fill_reg;
            if (miss_cnt_reg != '1) miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Lookup response captured on the falling edge, before L2 applies its own update
  always_ff @(negedge clk) begin
    if (reset) begin
      hit_cap_reg     <= 2'b00;
      l2_data_cap_reg <= '0;
    end else if (state_reg == S_LOOKUP) begin
      hit_cap_reg     <= cache_hit_in;
      l2_data_cap_reg <= data_from_L2;
    end
  end

  // Next-state and per-state output decode
  always_comb begin
    state_next      = state_reg;
    req_ack         = '0;
    resp_rdata      = '0;
    opcode_out      = OP_IDLE;
    bus_address_out = '0;
    bus_data_out    = '0;
    l2_fill_data    = '0;
    dmem_rd_en      = 1'b0;
    dmem_wr_en      = 1'b0;
    dmem_addr       = '0;
    dmem_wdata      = '0;
    case (state_reg)
      S_IDLE: begin
        if (grant_any) state_next = req_we[grant_idx] ? S_STORE : S_MEM_RD;
      end
      S_STORE: begin
        opcode_out      = OP_STORE;
        bus_address_out = addr_reg;
        bus_data_out    = wdata_reg;
        dmem_wr_en      = 1'b1;
        dmem_addr       = addr_reg;
        dmem_wdata      = wdata_reg;
        state_next      = S_ACK;
      end
      S_MEM_RD: begin
        dmem_rd_en = 1'b1;
        dmem_addr  = addr_reg;
        if (dmem_rvalid) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        opcode_out      = OP_LOAD;
        bus_address_out = addr_reg;
        l2_fill_data    = fill_reg;
        state_next      = S_ACK;
      end
      S_ACK: begin
        req_ack[winner_reg] = 1'b1;
        resp_rdata          = rdata_reg;
        state_next          = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign l2_hit_count  = hit_cnt_reg;
  assign l2_miss_count = miss_cnt_reg;

endmodule

// File: tb/tb_l2_bus_initiator.sv
// Directed testbench for l2_bus_initiator (NUM_CORES=2, CNT_W=2 so that
// counter saturation is reachable). Contention expectations follow the
// BUS_RR_ARB_EN macro.
module tb_l2_bus_initiator;

  localparam int NC = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] req_valid, req_we, req_ack;
  logic [NC*32-1:0] req_addr, req_wdata;
  logic [31:0]   resp_rdata, bus_address_out, bus_data_out, l2_fill_data;
  logic [6:0]    opcode_out;
  logic [1:0]    cache_hit_in;
  logic [31:0]   data_from_L2, dmem_addr, dmem_wdata, dmem_rdata;
  logic          dmem_rd_en, dmem_wr_en, dmem_rvalid;
  logic [CW-1:0] l2_hit_count, l2_miss_count;

  int checks   = 0;
  int failures = 0;

  l2_bus_initiator #(.NUM_CORES(NC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .resp_rdata(resp_rdata),
    .opcode_out(opcode_out), .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
    .l2_fill_data(l2_fill_data), .cache_hit_in(cache_hit_in), .data_from_L2(data_from_L2),
    .dmem_rd_en(dmem_rd_en), .dmem_wr_en(dmem_wr_en), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .l2_hit_count(l2_hit_count), .l2_miss_count(l2_miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns for driving and sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Full load transaction on core c; dmem answers in the lat-th MEM_RD cycle
  task automatic do_load(input int c, input logic [31:0] addr, input logic [1:0] hit,
                         input logic [31:0] l2d, input logic [31:0] memd, input int lat,
                         input logic [31:0] exp_rdata, input string tag);
    req_valid = '0;
    req_valid[c] = 1'b1;
    req_we    = '0;
    req_addr  = '0;
    req_addr[32*c +: 32] = addr;
    cache_hit_in = hit;
    data_from_L2 = l2d;
    dmem_rvalid  = 1'b0;
    tick();
    chk({tag, "_rd_en"}, 32'(dmem_rd_en), 32'd1);
    chk({tag, "_rd_addr"}, dmem_addr, addr);
    for (int i = 1; i < lat; i++) tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = memd;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    chk({tag, "_lk_op"}, 32'(opcode_out), 32'b0000011);
    chk({tag, "_lk_addr"}, bus_address_out, addr);
    chk({tag, "_lk_fill"}, l2_fill_data, memd);
    chk({tag, "_lk_rd_en"}, 32'(dmem_rd_en), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(req_ack), 32'(1 << c));
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    req_valid = '0;
    tick();
    chk({tag, "_ack_clr"}, 32'(req_ack), 32'd0);
    $display("load core%0d addr=%h rdata=%h hits=%0d misses=%0d", c, addr, exp_rdata,
             l2_hit_count, l2_miss_count);
  endtask

  int exp_order [3];

  initial begin
    reset = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    cache_hit_in = 2'b00; data_from_L2 = '0; dmem_rdata = '0; dmem_rvalid = 1'b0;
    do_reset();

    // Reset state
    chk("rst_op", 32'(opcode_out), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    chk("rst_hits", 32'(l2_hit_count), 32'd0);
    chk("rst_misses", 32'(l2_miss_count), 32'd0);
    chk("rst_rd_en", 32'(dmem_rd_en), 32'd0);
    chk("rst_wr_en", 32'(dmem_wr_en), 32'd0);

    // Store from core 0
    req_valid = 2'b01; req_we = 2'b01;
    req_addr  = {32'h0, 32'h0000_0010};
    req_wdata = {32'h0, 32'hDEAD_BEEF};
    tick();
    chk("st_op", 32'(opcode_out), 32'b0100011);
    chk("st_bus_addr", bus_address_out, 32'h10);
    chk("st_bus_data", bus_data_out, 32'hDEAD_BEEF);
    chk("st_wr_en", 32'(dmem_wr_en), 32'd1);
    chk("st_dmem_addr", dmem_addr, 32'h10);
    chk("st_dmem_wdata", dmem_wdata, 32'hDEAD_BEEF);
    chk("st_no_ack_yet", 32'(req_ack), 32'd0);
    tick();
    chk("st_ack", 32'(req_ack), 32'b01);
    chk("st_rdata", resp_rdata, 32'd0);
    chk("st_ack_op", 32'(opcode_out), 32'd0);
    chk("st_ack_wr_en", 32'(dmem_wr_en), 32'd0);
    req_valid = '0; req_we = '0;
    tick();
    chk("st_ack_clr", 32'(req_ack), 32'd0);
    $display("store core0 addr=00000010 data=deadbeef");

    // Load miss then load hit from core 1
    do_load(1, 32'h20, 2'b01, 32'hFFFF_0000, 32'h1234_5678, 3, 32'h1234_5678, "miss");
    chk("miss_cnt", 32'(l2_miss_count), 32'd1);
    chk("miss_hitcnt", 32'(l2_hit_count), 32'd0);
    do_load(1, 32'h20, 2'b10, 32'h1234_5678, 32'h0BAD_0BAD, 3, 32'h1234_5678, "hit");
    chk("hit_cnt", 32'(l2_hit_count), 32'd1);
    chk("hit_misscnt", 32'(l2_miss_count), 32'd1);
    // Code 11 is treated as a miss
    do_load(0, 32'h44, 2'b11, 32'hAAAA_AAAA, 32'h5555_0001, 1, 32'h5555_0001, "code11");
    chk("code11_misscnt", 32'(l2_miss_count), 32'd2);

    // Reset in the middle of a load
    req_valid = 2'b10; req_we = 2'b00; req_addr = {32'h30, 32'h0};
    tick();
    chk("mr_rd_en", 32'(dmem_rd_en), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = '0;
    chk("mr_rd_drop", 32'(dmem_rd_en), 32'd0);
    chk("mr_op", 32'(opcode_out), 32'd0);
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 1'b0;
    chk("mr_ack0", 32'(req_ack), 32'd0);
    tick();
    chk("mr_ack1", 32'(req_ack), 32'd0);
    chk("mr_op_late", 32'(opcode_out), 32'd0);
    chk("mr_rd_late", 32'(dmem_rd_en), 32'd0);
    chk("mr_hits", 32'(l2_hit_count), 32'd0);
    chk("mr_misses", 32'(l2_miss_count), 32'd0);
    $display("reset mid-load: no ack, counters cleared");

    // Contention: both cores request stores continuously
`ifdef BUS_RR_ARB_EN
    exp_order = '{0, 1, 0};
`else
    exp_order = '{0, 0, 0};
`endif
    req_valid = 2'b11; req_we = 2'b11;
    req_addr  = {32'h0000_0104, 32'h0000_0100};
    req_wdata = {32'h1111_1111, 32'h0000_0000};
    for (int t = 0; t < 3; t++) begin
      tick();
      chk($sformatf("ct%0d_dmem_addr", t), dmem_addr, 32'h100 + 32'(4 * exp_order[t]));
      tick();
      chk($sformatf("ct%0d_ack", t), 32'(req_ack), 32'(1 << exp_order[t]));
      $display("contention txn %0d ack=%b", t, req_ack);
      tick();
    end
    req_valid = '0; req_we = '0;
    tick();

    // Saturation of the 2-bit hit counter
    for (int k = 0; k < 5; k++) begin
      do_load(0, 32'h80, 2'b10, 32'hA5A5_0000 + 32'(k), 32'h0, 1, 32'hA5A5_0000 + 32'(k),
              $sformatf("sat%0d", k));
      chk($sformatf("sat%0d_cnt", k), 32'(l2_hit_count), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    chk("sat_misscnt", 32'(l2_miss_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_bus_initiator.md
Name: l2_bus_initiator

Overview:
- Bus-side initiator that drives the shared L2 cache request interface (opcode, address, store data, fill data) on behalf of NUM_CORES L1 requesters.
- Arbitrates one request at a time and runs write-through stores to L2 and data memory.
- Runs loads as a dmem read followed by an L2 lookup/fill.
- Returns load data to the winning core and keeps L2 hit/miss statistics.

Parameters:
NUM_CORES, 2, number of requesting cores (2..4)
CNT_W, 16, width of hit/miss statistic counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req_valid  in  NUM_CORES  per-core request pending; held until req_ack
req_we  in  NUM_CORES  1 = store, 0 = load
req_addr  in  NUM_CORES*32  per-core byte address, core i at [32i+31:32i]
req_wdata  in  NUM_CORES*32  per-core store data
req_ack  out  NUM_CORES  one-cycle pulse: request completed
resp_rdata  out  32  load data, valid in req_ack cycle
opcode_out  out  7  to L2: 0000011 load, 0100011 store, 0000000 idle
bus_address_out  out  32  to L2 address
bus_data_out  out  32  to L2 store data
l2_fill_data  out  32  to L2 miss-fill data input
cache_hit_in  in  2  from L2: 10 hit, 01 miss, 00 none
data_from_L2  in  32  from L2 load data
dmem_rd_en  out  1  dmem read strobe
dmem_wr_en  out  1  dmem write strobe
dmem_addr  out  32  dmem address
dmem_wdata  out  32  dmem write data
dmem_rdata  in  32  dmem read data
dmem_rvalid  in  1  dmem read data valid, arbitrary latency >=1 cycle
l2_hit_count  out  CNT_W  saturating L2 load-hit count
l2_miss_count  out  CNT_W  saturating L2 load-miss count

Behaviour:
- Clocking and reset:
  - Single clock clk, synchronous active-high reset.
  - FSM and all outputs update on the rising edge.
  - Lookup capture flops (hit flag, L2 data) update on the falling edge. This matches the L2 update edge, so they see pre-update L2 values.
- Reset values:
  - State IDLE, opcode_out = 0000000.
  - All other outputs 0, counters 0, arbitration pointer 0.
- Reset mid-operation aborts the transaction:
  - No req_ack is issued.
  - dmem_rd_en and dmem_wr_en drop the next cycle.
  - A late dmem_rvalid is ignored.
- States:
  - IDLE: opcode idle. If any req_valid, latch the winner index, addr, wdata and we. Go to STORE if we=1, else MEM_RD.
  - STORE (1 cycle):
    - opcode_out = 0100011, bus_address_out = addr, bus_data_out = wdata.
    - dmem_wr_en = 1, dmem_addr = addr, dmem_wdata = wdata.
    - Go to ACK.
  - MEM_RD: dmem_rd_en = 1 (level) with dmem_addr = addr. On dmem_rvalid, latch dmem_rdata into fill_q, drop dmem_rd_en and go to LOOKUP.
  - LOOKUP (1 cycle):
    - opcode_out = 0000011, bus_address_out = addr, l2_fill_data = fill_q.
    - Falling edge captures cache_hit_in and data_from_L2.
    - Next rising edge: hit (10) → rdata = captured data_from_L2, l2_hit_count++. Miss (01) → rdata = fill_q, l2_miss_count++. Code 00 or 11 is treated as miss.
    - Go to ACK.
  - ACK (1 cycle):
    - req_ack[winner] = 1, resp_rdata = rdata (loads; 0 for stores), opcode idle.
    - Go to IDLE. A new grant is not taken in the ACK cycle.
- Handshake and latency:
  - Latency from grant: store = 2 cycles to ack; load = dmem latency + 2 cycles.
  - req_* sampled only in IDLE. Changes to a pending core's inputs after grant are ignored.
  - A core deasserting req_valid before ack is a protocol violation; the transaction still completes.
- Arbitration: fixed priority, lowest index wins (see Optional Feature).
- Counters saturate at all-ones and do not wrap.
- Outputs not listed for a state are driven 0; opcode_out is 0000000 in every state except STORE and LOOKUP.

Optional Feature:
BUS_RR_ARB_EN
- Defined: round-robin arbitration.
  - Pointer starts at 0 after reset.
  - Search begins at pointer; the pointer moves to winner+1 (mod NUM_CORES) on each grant.
- Undefined: fixed priority, core 0 highest; no pointer register.

Test Plan:
- Store: core0 store addr 0x0000_0010 data 0xDEAD_BEEF → one STORE cycle with opcode 0100011, dmem_wr_en=1, dmem_addr 0x10; req_ack[0] 2 cycles after grant; resp_rdata 0.
- Load miss: core1 load 0x0000_0020, dmem returns 0x1234_5678 after 3 cycles, L2 reports 01 → LOOKUP shows l2_fill_data 0x1234_5678; ack[1] with resp_rdata 0x1234_5678; l2_miss_count = 1.
- Load hit: repeat the same load, L2 reports 10 with data_from_L2 0x1234_5678 → resp_rdata 0x1234_5678; l2_hit_count = 1, miss count unchanged.
- Contention: req_valid = 2'b11 held through three transactions → fixed priority: core0, core0, core0. With BUS_RR_ARB_EN: core0, core1, core0.
- Reset mid-load: assert reset during MEM_RD, then dmem_rvalid two cycles later → no req_ack, dmem_rd_en 0, opcode 0000000, counters 0.
- Saturation: CNT_W=2, five L2 hits → l2_hit_count stays 3.
